hs_arbiter: RTL
===============

HS_ARBITER -- requirements
Module: hs_arbiter

Interface
REQ-001 Parameter DW, default 3, data width of every channel.
REQ-002 Parameter CW, default 8, width of each per-requester transfer counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req_a / req_b  input  1 each  four-phase request from requester A / B.
REQ-006 Port data_a / data_b  input  DW each  requester payload, stable while its req is high.
REQ-007 Port ack_a / ack_b  output  1 each  four-phase acknowledge to requester A / B.
REQ-008 Port req_out  output  1  four-phase request into the downstream handshake pipeline.
REQ-009 Port ack_out  input  1  four-phase acknowledge from the downstream pipeline.
REQ-010 Port data_out  output  DW  registered payload presented with req_out.
REQ-011 Port gnt  output  1  current or last owner (0=A, 1=B).
REQ-012 Port cnt_a / cnt_b  output  CW each  completed transfers per requester.

Function
REQ-013 FSM states: IDLE, SEND, RET; all outputs registered.
REQ-014 IDLE -> SEND requires ack_out_s=0 and at least one of req_a_s/req_b_s=1 (suffix _s = value after the optional synchroniser, see REQ-026).
REQ-015 Exactly one requester pending in IDLE: that requester is granted.
REQ-016 Both requesters pending in IDLE: grant goes to the requester not served last (round-robin); after reset, A has priority.
REQ-017 On entry to SEND: data_out <= granted data, gnt <= granted id, req_out <= 1, in the same edge.
REQ-018 SEND -> RET when ack_out_s=1: req_out <= 0, ack of the granted requester <= 1.
REQ-019 RET -> IDLE when ack_out_s=0 and the granted req_s=0: granted ack <= 0, the granted counter increments by 1, and the round-robin pointer moves to the other requester.
REQ-020 Counters wrap from 2^CW-1 to 0 with no flag.
REQ-021 The non-granted ack stays 0 at all times; a non-granted request is held pending without loss.
REQ-022 data_out remains stable from SEND entry until the next SEND entry.
REQ-023 A requester dropping req in SEND (protocol violation) is ignored; the transfer completes normally.
REQ-024 Minimum cycle count per transfer, synchroniser disabled: 1 (IDLE->SEND) + 1 + 1 = 3 clocks plus environment response time.

Reset
REQ-025 rst_n low forces immediately: state=IDLE, req_out=0, ack_a=ack_b=0, data_out=0, gnt=0, cnt_a=cnt_b=0, pointer=A, synchroniser flops=0; a transfer in flight is abandoned with no counter update.

Configuration
REQ-026 Macro HS_ARBITER_SYNC_EN defined: req_a, req_b and ack_out each pass through a two-flop synchroniser (2 clocks of added latency per input edge).
REQ-027 Macro HS_ARBITER_SYNC_EN undefined: those inputs are used directly (_s = raw input), for synchronous environments only.

Structure
REQ-028 Shared package hs_pkg holds the FSM state enum (IDLE, SEND, RET), default DW and CW constants, and requester id constants ID_A=0, ID_B=1.
REQ-029 Sub-module hs_sync2: a reset-able two-flop single-bit synchroniser, instantiated three times when HS_ARBITER_SYNC_EN is defined.

Verification
REQ-030 Sync off; req_a=1, data_a=3'b101 -> next clock req_out=1, data_out=101, gnt=0; ack_out=1 -> ack_a=1, req_out=0; ack_out=0 and req_a=0 -> ack_a=0, cnt_a=1.
REQ-031 After reset, req_a and req_b raised in the same cycle (data 001/110) -> A served first, then B; gnt sequence 0,1; cnt_a=cnt_b=1.
REQ-032 req_a and req_b held continuously for 6 transfers -> grants alternate A,B,A,B,A,B; ack_b never high during an A transfer.
REQ-033 CW=2, 5 transfers from A -> cnt_a reads 1,2,3,0,1.
REQ-034 rst_n pulled low in SEND -> same clock req_out=0, ack=0, counters 0; after release with req_b=1 -> B granted normally.
REQ-035 Sync on; req_a rise -> req_out rises exactly 3 clocks later (2 sync + 1 registered FSM edge).

Source files
------------

// File: rtl/hs_arbiter_pkg.sv
// hs_pkg: shared FSM state type, default widths and requester ids for hs_arbiter
package hs_pkg;
  typedef enum logic [1:0] {IDLE, SEND, RET} state_t;
  localparam int DW_DEF = 3;
  localparam int CW_DEF = 8;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
endpackage

// File: rtl/hs_arbiter_if.sv
// hs_arbiter_if: two-requester four-phase handshake bus plus downstream channel and counters
interface hs_arbiter_if import hs_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic          req_a, req_b, ack_a, ack_b;
  logic [DW-1:0] data_a, data_b, data_out;
  logic          req_out, ack_out, gnt;
  logic [CW-1:0] cnt_a, cnt_b;
  modport slave (
    input  req_a, req_b, data_a, data_b, ack_out,
    output ack_a, ack_b, req_out, data_out, gnt, cnt_a, cnt_b
  );
  modport master (
    output req_a, req_b, data_a, data_b, ack_out,
    input  ack_a, ack_b, req_out, data_out, gnt, cnt_a, cnt_b
  );
endinterface

// File: rtl/hs_arbiter_sync2.sv
// hs_sync2: resettable two-flop single-bit synchroniser
module hs_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  // shift the input through two flops, clearing both on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/hs_arbiter.sv
// hs_arbiter: round-robin two-way four-phase handshake arbiter; HS_ARBITER_SYNC_EN adds input synchronisers
module hs_arbiter import hs_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  hs_arbiter_if.slave  bus
);
  state_t        state, state_nx;
  logic          req_a_s, req_b_s, ack_s, ptr, pick, req_g;
  logic [DW-1:0] data_sel;
`ifdef HS_ARBITER_SYNC_EN
  hs_sync2 u_sync_a (.clk(clk), .rst_n(rst_n), .d(bus.req_a),   .q(req_a_s));
  hs_sync2 u_sync_b (.clk(clk), .rst_n(rst_n), .d(bus.req_b),   .q(req_b_s));
  hs_sync2 u_sync_k (.clk(clk), .rst_n(rst_n), .d(bus.ack_out), .q(ack_s));
`else
  assign req_a_s = bus.req_a;
  assign req_b_s = bus.req_b;
  assign ack_s   = bus.ack_out;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // grant choice and next state; a contested grant goes to the round-robin pointer
  always_comb begin
    pick     = (req_a_s & req_b_s) ? ptr : req_b_s;
    data_sel = pick ? bus.data_b : bus.data_a;
    req_g    = bus.gnt ? req_b_s : req_a_s;
    state_nx = (state == IDLE && !ack_s && (req_a_s | req_b_s)) ? SEND :
               (state == SEND && ack_s)                         ? RET  :
               (state == RET && !ack_s && !req_g)               ? IDLE : state;
  end
  // registered outputs, updated only on the edge that performs a transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.req_out  <= 1'b0;
      bus.ack_a    <= 1'b0;
      bus.ack_b    <= 1'b0;
      bus.data_out <= '0;
      bus.gnt      <= ID_A;
      bus.cnt_a    <= '0;
      bus.cnt_b    <= '0;
      ptr          <= ID_A;
    end else if (state == IDLE && state_nx == SEND) begin
      bus.data_out <= data_sel;
      bus.gnt      <= pick;
      bus.req_out  <= 1'b1;
    end else if (state == SEND && state_nx == RET) begin
      bus.req_out <= 1'b0;
      bus.ack_a   <= bus.gnt == ID_A;
      bus.ack_b   <= bus.gnt == ID_B;
    end else if (state == RET && state_nx == IDLE) begin
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      if (bus.gnt == ID_B) bus.cnt_b <= bus.cnt_b + CW'(1);
      else bus.cnt_a <= bus.cnt_a + CW'(1);
      ptr <= ~bus.gnt;
    end
endmodule
